carpark_gate_ctrl: RTL and testbench
====================================

// Module: carpark_gate_ctrl
// PURPOSE
//  Entry-gate and slot-occupancy controller for the 4-slot car park.
//  - Allocates a free slot to an arriving car and drives the entry gate.
//  - Frees slots on departure events.
//  - Publishes the occupancy vector occ = {A,B,C,D}, the same slot-sensor
//    encoding the car park pattern checker consumes.
// PARAMETERS
//  OPEN_TIMEOUT  16  cycles gate stays open waiting for pass_sensor before abort (>=2)
//  CLOSE_HOLD    4   cycles gate held closed after a car before next grant (>=1)
//  TMR_W         5   timer width; must hold max(OPEN_TIMEOUT,CLOSE_HOLD)
// PORTS
//  clk           in   1  clock, rising edge
//  rst_n         in   1  asynchronous active-low reset
//  arrive_req    in   1  level; car at entry, held until arrive_ack or arrive_rej
//  arrive_ack    out  1  1-cycle pulse; slot granted, slot_id valid this cycle
//  arrive_rej    out  1  1-cycle pulse; car park full, request refused
//  slot_id       out  2  granted slot: 0=A 1=B 2=C 3=D; held until next grant
//  pass_sensor   in   1  car has passed the gate (level, sampled)
//  depart_valid  in   1  1-cycle strobe; car leaving slot depart_slot
//  depart_slot   in   2  slot being vacated (0=A..3=D)
//  depart_err    out  1  1-cycle pulse; departure from an already-free slot
//  gate_open     out  1  gate actuator, 1=open
//  timeout       out  1  1-cycle pulse; OPEN aborted, reservation released
//  occ           out  4  {A,B,C,D}, 1=occupied/reserved
//  free_count    out  3  4 - popcount(occ), combinational from occ
//  full          out  1  occ==4'b1111
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, occ=0, slot_id=0,
//   gate_open=0, all pulses 0, timer=0 => free_count=4, full=0.
//   Reset mid-OPEN closes gate at once; all reservations are lost.
//  FSM IDLE -> OPEN -> CLOSE -> IDLE; all outputs registered except free_count/full.
//  IDLE: arrive_req && !full  -> pick lowest free slot (A first).
//     - Set its occ bit, drive slot_id, pulse arrive_ack.
//     - gate_open=1 and state=OPEN from the next edge; latency req->ack 1 cycle.
//   arrive_req && full -> pulse arrive_rej, stay IDLE; rej repeats every
//    2nd cycle while req held (rej cycle, then 1 idle cycle).
//  OPEN: timer counts from 0 each cycle.
//   pass_sensor=1 -> gate_open=0, state CLOSE, slot stays occupied.
//   timer reaches OPEN_TIMEOUT-1 without pass:
//     - Clear the reserved occ bit and pulse timeout.
//     - gate_open=0, state CLOSE.
//   pass_sensor and timeout in the same cycle: pass wins, no timeout.
//  CLOSE: gate_open=0 for CLOSE_HOLD cycles, then IDLE; arrive_req ignored
//   (no ack/rej) in OPEN and CLOSE.
//  Departure (any state): depart_valid clears occ[3-depart_slot].
//   - Bit already 0: pulse depart_err, occ unchanged.
//   - Same cycle as a grant: grant uses the pre-edge occ; both updates apply.
//   - A departure freeing a slot lets an IDLE grant succeed next cycle, not
//     the same cycle.
//   - Departure of the slot being timed out in the same cycle: single clear,
//     no depart_err.
//  Note: full-rejection loops while any car held req; no starvation
//   guarantees beyond lowest-slot-first.
// TESTING
//  1 reset, req=1 -> ack at cycle 1, slot_id=0, occ=1000, gate_open=1, free_count=3
//  2 4 arrivals each with pass -> slot_ids 0,1,2,3; occ=1111, full=1; 5th req -> arrive_rej, gate stays 0
//  3 grant, no pass for 16 cycles -> timeout pulse, occ bit cleared, gate_open=0, IDLE after 4-cycle hold
//  4 occ=1111, depart slot 2 -> occ=1101; next req -> slot_id=2; depart slot 2 twice -> depart_err on 2nd only
//  5 depart_valid on the same cycle as a grant in IDLE -> both reflected in occ next cycle, no depart_err
//  6 assert rst_n=0 during OPEN -> gate_open=0 and occ=0000 immediately, asynchronously

Source files
------------

// File: rtl/carpark_gate_ctrl.sv
// Entry-gate and slot-occupancy controller for a 4-slot car park.
// An arriving car gets the lowest free slot (A first) and the gate opens.
// The gate closes when the car passes, or after a timeout that releases the
// reservation. A short hold follows before the next grant.
// Departures clear slots in any state.
// occ is published as {A,B,C,D}, so slot n is bit 3-n.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | gate closed; grant or reject arrival requests
// ST_OPEN  | gate open for the granted slot, waiting for pass_sensor
// ST_CLOSE | gate closed, holding before the next grant is allowed
module carpark_gate_ctrl #(
  parameter int OPEN_TIMEOUT = 16,
  parameter int CLOSE_HOLD   = 4,
  parameter int TMR_W        = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arrive_req,
  output logic       arrive_ack,
  output logic       arrive_rej,
  output logic [1:0] slot_id,
  input  logic       pass_sensor,
  input  logic       depart_valid,
  input  logic [1:0] depart_slot,
  output logic       depart_err,
  output logic       gate_open,
  output logic       timeout,
  output logic [3:0] occ,
  output logic [2:0] free_count,
  output logic       full
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_CLOSE = 2'd2
  } state_t;

  localparam logic [TMR_W-1:0] OPEN_LAST  = TMR_W'(OPEN_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] CLOSE_LAST = TMR_W'(CLOSE_HOLD - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timer_nxt;
  logic [3:0]       r_occ;
  logic [3:0]       w_occ_nxt;
  logic [1:0]       r_slot_id;
  logic [1:0]       w_slot_nxt;
  logic             r_gate_open;
  logic             w_gate_nxt;
  logic             r_ack;
  logic             w_ack_nxt;
  logic             r_rej;
  logic             w_rej_nxt;
  logic             r_derr;
  logic             w_derr_nxt;
  logic             r_tmo;
  logic             w_tmo_nxt;

  logic             w_full;
  logic [1:0]       w_grant_slot;
  logic [3:0]       w_grant_mask;
  logic [3:0]       w_set_mask;
  logic [3:0]       w_tmo_clr;
  logic [3:0]       w_dep_mask;
  logic [3:0]       w_dep_clr;
  logic [3:0]       w_rsv_mask;

  assign w_full     = &r_occ;
  // Slot n lives at occ bit 3-n, so a right shift of the A bit addresses it.
  assign w_dep_mask = depart_valid ? (4'b1000 >> depart_slot) : 4'b0000;
  assign w_dep_clr  = w_dep_mask & r_occ;
  assign w_derr_nxt = |(w_dep_mask & ~r_occ);
  assign w_rsv_mask = 4'b1000 >> r_slot_id;

  // Lowest free slot, A first; only used when the car park is not full.
  always_comb begin
    w_grant_slot = 2'd0;
    w_grant_mask = 4'b0000;
    if (!r_occ[3]) begin
      w_grant_slot = 2'd0;
      w_grant_mask = 4'b1000;
    end else if (!r_occ[2]) begin
      w_grant_slot = 2'd1;
      w_grant_mask = 4'b0100;
    end else if (!r_occ[1]) begin
      w_grant_slot = 2'd2;
      w_grant_mask = 4'b0010;
    end else if (!r_occ[0]) begin
      w_grant_slot = 2'd3;
      w_grant_mask = 4'b0001;
    end
  end

  // Next-state and registered-output decode for the gate sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_slot_nxt  = r_slot_id;
    w_gate_nxt  = 1'b0;
    w_ack_nxt   = 1'b0;
    w_rej_nxt   = 1'b0;
    w_tmo_nxt   = 1'b0;
    w_set_mask  = 4'b0000;
    w_tmo_clr   = 4'b0000;
    case (r_state)
      ST_IDLE: begin
        w_timer_nxt = '0;
        if (arrive_req) begin
          if (!w_full) begin
            w_set_mask  = w_grant_mask;
            w_slot_nxt  = w_grant_slot;
            w_ack_nxt   = 1'b1;
            w_gate_nxt  = 1'b1;
            w_state_nxt = ST_OPEN;
          end else if (!r_rej) begin
            // A held request sees a reject on every second cycle only.
            w_rej_nxt = 1'b1;
          end
        end
      end
      ST_OPEN: begin
        w_gate_nxt = 1'b1;
        if (pass_sensor) begin
          // Pass has priority over a timeout in the same cycle.
          w_gate_nxt  = 1'b0;
          w_timer_nxt = '0;
          w_state_nxt = ST_CLOSE;
        end else if (r_timer == OPEN_LAST) begin
          w_tmo_nxt   = 1'b1;
          w_tmo_clr   = w_rsv_mask;
          w_gate_nxt  = 1'b0;
          w_timer_nxt = '0;
          w_state_nxt = ST_CLOSE;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      ST_CLOSE: begin
        if (r_timer == CLOSE_LAST) begin
          w_timer_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: begin
        w_timer_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
    // A grant only sets a free bit and a departure only clears an occupied
    // one, so the two updates never collide.
    w_occ_nxt = (r_occ & ~w_dep_clr & ~w_tmo_clr) | w_set_mask;
  end

  // State, timer, occupancy and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_occ       <= 4'b0000;
      r_slot_id   <= 2'd0;
      r_gate_open <= 1'b0;
      r_ack       <= 1'b0;
      r_rej       <= 1'b0;
      r_derr      <= 1'b0;
      r_tmo       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_occ       <= w_occ_nxt;
      r_slot_id   <= w_slot_nxt;
      r_gate_open <= w_gate_nxt;
      r_ack       <= w_ack_nxt;
      r_rej       <= w_rej_nxt;
      r_derr      <= w_derr_nxt;
      r_tmo       <= w_tmo_nxt;
    end
  end

  assign arrive_ack = r_ack;
  assign arrive_rej = r_rej;
  assign slot_id    = r_slot_id;
  assign depart_err = r_derr;
  assign gate_open  = r_gate_open;
  assign timeout    = r_tmo;
  assign occ        = r_occ;
  assign full       = w_full;
  assign free_count = 3'd4 - ({2'b00, r_occ[0]} + {2'b00, r_occ[1]}
                            + {2'b00, r_occ[2]} + {2'b00, r_occ[3]});

endmodule

// File: tb/tb_carpark_gate_ctrl.sv
// Testbench for carpark_gate_ctrl.
// A reference model tracks the slot set, the grant time and the earliest
// cycle the gate may grant again.
// Outputs are compared 1 time unit after each rising edge.
module tb_carpark_gate_ctrl;
  localparam int OPEN_TIMEOUT = 16;
  localparam int CLOSE_HOLD   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arrive_req = 1'b0;
  logic       pass_sensor = 1'b0;
  logic       depart_valid = 1'b0;
  logic [1:0] depart_slot = 2'd0;
  logic       arrive_ack, arrive_rej, depart_err, gate_open, timeout, full;
  logic [1:0] slot_id;
  logic [3:0] occ;
  logic [2:0] free_count;

  carpark_gate_ctrl #(.OPEN_TIMEOUT(OPEN_TIMEOUT), .CLOSE_HOLD(CLOSE_HOLD), .TMR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .arrive_req(arrive_req), .arrive_ack(arrive_ack),
    .arrive_rej(arrive_rej), .slot_id(slot_id), .pass_sensor(pass_sensor),
    .depart_valid(depart_valid), .depart_slot(depart_slot), .depart_err(depart_err),
    .gate_open(gate_open), .timeout(timeout), .occ(occ), .free_count(free_count),
    .full(full)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: occ holds slot n at bit 3-n.
  logic [3:0] m_occ;
  logic [1:0] m_slot;
  bit         m_open;
  bit         m_prev_rej;
  int         m_grant_cyc;
  int         m_idle_from;
  int         cyc;
  bit         e_ack, e_rej, e_derr, e_tmo;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_occ       = 4'b0000;
    m_slot      = 2'd0;
    m_open      = 1'b0;
    m_prev_rej  = 1'b0;
    m_grant_cyc = 0;
    m_idle_from = 0;
    e_ack = 1'b0; e_rej = 1'b0; e_derr = 1'b0; e_tmo = 1'b0;
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, "_ack"},  8'(arrive_ack), 8'(e_ack));
    chk({pfx, "_rej"},  8'(arrive_rej), 8'(e_rej));
    chk({pfx, "_derr"}, 8'(depart_err), 8'(e_derr));
    chk({pfx, "_tmo"},  8'(timeout),    8'(e_tmo));
    chk({pfx, "_gate"}, 8'(gate_open),  8'(m_open));
    chk({pfx, "_slot"}, 8'(slot_id),    8'(m_slot));
    chk({pfx, "_occ"},  8'(occ),        8'(m_occ));
    chk({pfx, "_free"}, 8'(free_count), 8'(4 - $countones(m_occ)));
    chk({pfx, "_full"}, 8'(full),       8'(m_occ == 4'b1111));
  endtask

  // One clock: drive inputs, advance the model by the rules, compare.
  task automatic step(input string pfx, input bit req, input bit pass,
                      input bit dv, input logic [1:0] ds);
    logic [3:0] clr, set;
    int idx;
    arrive_req   = req;
    pass_sensor  = pass;
    depart_valid = dv;
    depart_slot  = ds;
    @(posedge clk);
    cyc++;
    e_ack = 1'b0; e_rej = 1'b0; e_derr = 1'b0; e_tmo = 1'b0;
    clr = 4'b0000;
    set = 4'b0000;
    if (dv) begin
      idx = 3 - int'(ds);
      if (m_occ[idx]) clr[idx] = 1'b1;
      else            e_derr = 1'b1;
    end
    if (m_open) begin
      if (pass) begin
        m_open      = 1'b0;
        m_idle_from = cyc + CLOSE_HOLD + 1;
      end else if (cyc - m_grant_cyc == OPEN_TIMEOUT) begin
        e_tmo = 1'b1;
        clr[3 - int'(m_slot)] = 1'b1;
        m_open      = 1'b0;
        m_idle_from = cyc + CLOSE_HOLD + 1;
      end
    end else if (cyc >= m_idle_from && req) begin
      if (m_occ == 4'b1111) begin
        e_rej = !m_prev_rej;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (!m_occ[3 - k] && !e_ack) begin
            e_ack  = 1'b1;
            m_slot = 2'(k);
            set[3 - k] = 1'b1;
          end
        end
        m_open      = 1'b1;
        m_grant_cyc = cyc;
      end
    end
    m_prev_rej = e_rej;
    m_occ = (m_occ & ~clr) | set;
    #1;
    check_all(pfx);
  endtask

  // Request until granted (bounded), then let the car pass.
  task automatic arrive_pass(input string pfx);
    int n = 0;
    do begin
      step(pfx, 1'b1, 1'b0, 1'b0, 2'd0);
      n++;
    end while (!e_ack && n < 40);
    if (!e_ack) begin
      total++;
      bad++;
      $display("FAIL %s_grant_wait observed=no_ack expected=ack_within_40", pfx);
    end
    step({pfx, "_pass"}, 1'b0, 1'b1, 1'b0, 2'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    model_reset();
    #1;
    check_all("reset");
    #11 rst_n = 1'b1;

    // First arrival right after reset.
    step("t1", 1'b1, 1'b0, 1'b0, 2'd0);
    chk("t1_ack_const", 8'(arrive_ack), 8'd1);
    chk("t1_occ_const", 8'(occ), 8'b1000);
    chk("t1_free_const", 8'(free_count), 8'd3);
    step("t1_pass", 1'b0, 1'b1, 1'b0, 2'd0);

    // Fill the remaining slots, then reject while full.
    arrive_pass("t2b");
    arrive_pass("t2c");
    arrive_pass("t2d");
    chk("t2_slot_d", 8'(slot_id), 8'd3);
    for (int i = 0; i < 6; i++) step("t2_wait", 1'b0, 1'b0, 1'b0, 2'd0);
    step("t2_rej1", 1'b1, 1'b0, 1'b0, 2'd0);
    chk("t2_rej_const", 8'(arrive_rej), 8'd1);
    step("t2_rej_gap", 1'b1, 1'b0, 1'b0, 2'd0);
    step("t2_rej2", 1'b1, 1'b0, 1'b0, 2'd0);
    step("t2_drop", 1'b0, 1'b0, 1'b0, 2'd0);

    // Free slot C, regrant it, double departure.
    step("t4_dep", 1'b0, 1'b0, 1'b1, 2'd2);
    chk("t4_occ_const", 8'(occ), 8'b1101);
    arrive_pass("t4_re");
    chk("t4_slot_const", 8'(slot_id), 8'd2);
    step("t4_dep1", 1'b0, 1'b0, 1'b1, 2'd2);
    step("t4_dep2", 1'b0, 1'b0, 1'b1, 2'd2);
    chk("t4_err_const", 8'(depart_err), 8'd1);

    // Open timeout on the reserved slot.
    for (int i = 0; i < 6; i++) step("t3_wait", 1'b0, 1'b0, 1'b0, 2'd0);
    step("t3_grant", 1'b1, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < OPEN_TIMEOUT; i++) step("t3_open", 1'b0, 1'b0, 1'b0, 2'd0);
    chk("t3_tmo_const", 8'(timeout), 8'd1);
    chk("t3_occ_const", 8'(occ), 8'b1101);
    for (int i = 0; i < CLOSE_HOLD; i++) step("t3_hold", 1'b1, 1'b0, 1'b0, 2'd0);

    // Grant and departure in the same IDLE cycle.
    step("t5", 1'b1, 1'b0, 1'b1, 2'd0);
    chk("t5_occ_const", 8'(occ), 8'b0111);

    // Asynchronous reset while the gate is open.
    step("t6_open", 1'b0, 1'b0, 1'b0, 2'd0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("t6_rst");
    chk("t6_gate_const", 8'(gate_open), 8'd0);
    #1 rst_n = 1'b1;

    // Randomised traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      step("rnd", ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rnd_rst");
        #1 rst_n = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
